// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard/stall
// controller. The datapath (master) presents the stage occupants; the
// controller (slave) returns freeze, bubble, flush and SRAM-wait controls.
interface pipeline_ctrl_if #(
  parameter int REG_W = 4
);

  // ID-stage operands
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_use_src1;
  logic             id_two_src;

  // EXE-stage occupant
  logic [REG_W-1:0] exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_r_en;
  logic             branch_taken;

  // MEM-stage occupant
  logic [REG_W-1:0] mem_dest;
  logic             mem_wb_en;
  logic             mem_r_en;
  logic             mem_w_en;

  // Controller responses
  logic             freeze;
  logic             bubble_exe;
  logic             flush;
  logic             stall_all;
  logic             mem_ready;
  logic [15:0]      stall_cycles;

  modport master (
    output id_src1, id_src2, id_use_src1, id_two_src,
    output exe_dest, exe_wb_en, exe_mem_r_en, branch_taken,
    output mem_dest, mem_wb_en, mem_r_en, mem_w_en,
    input  freeze, bubble_exe, flush, stall_all, mem_ready, stall_cycles
  );

  modport slave (
    input  id_src1, id_src2, id_use_src1, id_two_src,
    input  exe_dest, exe_wb_en, exe_mem_r_en, branch_taken,
    input  mem_dest, mem_wb_en, mem_r_en, mem_w_en,
    output freeze, bubble_exe, flush, stall_all, mem_ready, stall_cycles
  );

endinterface

// File: rtl/pipeline_ctrl.sv
// Central hazard and stall controller for a 5-stage pipeline.
// Priority (highest first): SRAM wait stall, taken-branch flush, RAW hazard
// bubble. All controls are combinational; only the wait-state FSM and the
// saturating stall-cycle counter hold state.
module pipeline_ctrl #(
  parameter int MEM_WAIT = 4,  // total stall cycles per SRAM access, 1..15
  parameter int FWD_EN   = 0,  // 1: forwarding present, only load-use stalls
  parameter int REG_W    = 4
) (
  input logic            clk,
  input logic            rst,
  pipeline_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // BUSY counts down from here; the IDLE cycle that accepts the access is
  // the first stall cycle and the cnt==0 BUSY cycle is the last one.
  localparam logic [3:0] WAIT_LOAD = (MEM_WAIT > 1) ? 4'(MEM_WAIT - 2) : 4'd0;

  logic [1:0]       state, state_next;
  logic [3:0]       cnt, cnt_next;
  logic             mem_req;
  logic             fsm_stall, fsm_ready;

  logic [REG_W-1:0] src1, src2, exe_dest, mem_dest;
  logic             rd1_exe, rd2_exe, rd1_mem, rd2_mem;
  logic             hazard;

  logic             freeze_c, bubble_c, flush_c;
  logic             freeze_o, stall_o;
  logic [15:0]      stall_cnt;

  assign mem_req  = bus.mem_r_en | bus.mem_w_en;
  assign src1     = bus.id_src1;
  assign src2     = bus.id_src2;
  assign exe_dest = bus.exe_dest;
  assign mem_dest = bus.mem_dest;

  // Wait-state FSM next-state and stall/ready decode.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_next = state;
    cnt_next   = cnt;
    fsm_stall  = 1'b0;
    fsm_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          fsm_stall = 1'b1;
          if (MEM_WAIT == 1) begin
            state_next = DONE;
          end else begin
            state_next = BUSY;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      BUSY: begin
        // Request changes are ignored here; the MEM register is frozen.
        fsm_stall = 1'b1;
        if (cnt == 4'd0) state_next = DONE;
        else             cnt_next   = cnt - 4'd1;
      end
      DONE: begin
        fsm_ready  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // RAW hazard detection: which ID operands name an in-flight destination.
  always_comb begin
    rd1_exe = bus.id_use_src1 & (src1 == exe_dest);
    rd2_exe = bus.id_two_src  & (src2 == exe_dest);
    rd1_mem = bus.id_use_src1 & (src1 == mem_dest);
    rd2_mem = bus.id_two_src  & (src2 == mem_dest);
    if (FWD_EN != 0)
      hazard = bus.exe_mem_r_en & (rd1_exe | rd2_exe);
    else
      hazard = (bus.exe_wb_en & (rd1_exe | rd2_exe))
             | (bus.mem_wb_en & (rd1_mem | rd2_mem));
  end

  // Fixed-priority merge of stall, branch flush and hazard bubble.
  always_comb begin
    freeze_c = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    if (fsm_stall) begin
      // The taken branch sits in the frozen EXE register and is flushed
      // once the stall lifts.
      freeze_c = 1'b1;
    end else if (bus.branch_taken) begin
      // The ID instruction is being killed, so its hazard does not matter.
      flush_c = 1'b1;
    end else if (hazard) begin
      freeze_c = 1'b1;
      bubble_c = 1'b1;
    end
  end

  // While reset is high every control is forced low, even though IDLE with
  // a pending request would otherwise decode a stall.
  assign freeze_o       = freeze_c  & ~rst;
  assign stall_o        = fsm_stall & ~rst;
  assign bus.freeze     = freeze_o;
  assign bus.stall_all  = stall_o;
  assign bus.bubble_exe = bubble_c  & ~rst;
  assign bus.flush      = flush_c   & ~rst;
  assign bus.mem_ready  = fsm_ready & ~rst;

  // Saturating count of cycles in which the front end was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= 16'd0;
    else if ((freeze_o | stall_o) && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

  assign bus.stall_cycles = stall_cnt;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and stall controller for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
- Generates three things:
  - freeze for the IF stage PC and IF/ID register.
  - bubble/flush controls for the ID/EXE register.
  - a global stall while the MEM stage waits on a multi-cycle SRAM access.
- Combines RAW hazard detection, branch flush sequencing and a wait-state FSM, with fixed priority between them.

Parameters:
- MEM_WAIT, 4, total stall cycles per SRAM access (legal range 1..15).
- FWD_EN, 0, 1 = forwarding unit present: only load-use hazards stall; 0 = any RAW hazard against EXE/MEM stalls.
- REG_W, 4, register-index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- id_src1  input  REG_W  ID operand 1 index.
- id_src2  input  REG_W  ID operand 2 index.
- id_use_src1  input  1  ID instruction reads src1.
- id_two_src  input  1  ID instruction reads src2.
- exe_dest  input  REG_W  EXE destination index.
- exe_wb_en  input  1  EXE instruction writes back.
- exe_mem_r_en  input  1  EXE instruction is a load.
- mem_dest  input  REG_W  MEM destination index.
- mem_wb_en  input  1  MEM instruction writes back.
- mem_r_en  input  1  MEM stage load.
- mem_w_en  input  1  MEM stage store.
- branch_taken  input  1  EXE resolved taken branch.
- freeze  output  1  hold PC and IF/ID register.
- bubble_exe  output  1  load NOP into ID/EXE register.
- flush  output  1  clear IF/ID and ID/EXE (branch kill).
- stall_all  output  1  hold every pipeline register (SRAM wait).
- mem_ready  output  1  SRAM access completes this cycle.
- stall_cycles  output  16  saturating count of cycles with freeze or stall_all high.

Behaviour:
- Reset (async, rst=1):
  - FSM state = IDLE, wait counter = 0, stall_cycles = 0.
  - All combinational outputs forced to 0 while rst is high.
- FSM states: IDLE, BUSY, DONE.
  - IDLE with mem_r_en|mem_w_en: stall_all=1 this cycle.
    - If MEM_WAIT=1, next state is DONE.
    - Otherwise next state is BUSY and cnt <= MEM_WAIT-2.
  - BUSY: stall_all=1. If cnt==0, next state is DONE; else cnt--.
  - DONE: stall_all=0, mem_ready=1, next state is IDLE. The pipeline advances at this edge.
  - Access presented in cycle t therefore gives stall_all high for cycles t..t+MEM_WAIT-1 and mem_ready high in cycle t+MEM_WAIT.
- Back-to-back memory instructions: IDLE samples the new MEM occupant the cycle after DONE, so there is no idle gap in the stall pattern beyond the single DONE cycle.
- mem_r_en/mem_w_en changing during BUSY is ignored. The register is frozen, so this cannot happen legally; the bench checks that the counter is unaffected.
- Hazard term h:
  - s1 = id_use_src1, s2 = id_two_src.
  - FWD_EN=0: h = exe_wb_en & ((s1 & id_src1==exe_dest) | (s2 & id_src2==exe_dest)) | mem_wb_en & ((s1 & id_src1==mem_dest) | (s2 & id_src2==mem_dest)).
  - FWD_EN=1: h = exe_mem_r_en & ((s1 & id_src1==exe_dest) | (s2 & id_src2==exe_dest)).
- Priority, highest first:
  1. stall_all: freeze=1, bubble_exe=0, flush=0. branch_taken is held by the frozen EXE register and is honoured after the stall.
  2. branch_taken: flush=1, freeze=0, bubble_exe=0. The killed ID instruction's hazard is irrelevant.
  3. h: freeze=1, bubble_exe=1.
  4. Otherwise all zero.
- Output timing: all outputs except stall_cycles are combinational from inputs and FSM state, so there is zero-cycle latency. stall_cycles is registered.
- stall_cycles increments at the clock edge when (freeze|stall_all) was 1; it saturates at 16'hFFFF and does not wrap.
- Reset asserted mid-access: the FSM returns to IDLE immediately and stall_all drops asynchronously. After release, a still-present mem_r_en starts a fresh full MEM_WAIT sequence.

Test Plan:
- Memory wait: MEM_WAIT=4, load in MEM at cycle 2 → stall_all high cycles 2–5, mem_ready high cycle 6 only, stall_cycles=4 after cycle 6.
- Back-to-back: two consecutive stores → stall_all pattern 1111 0 1111 0, and mem_ready pulses exactly twice.
- RAW hazard, FWD_EN=0: exe_dest=3, exe_wb_en=1, id_src1=3, id_use_src1=1 → freeze=1 and bubble_exe=1 in the same cycle.
  - Same stimulus with id_use_src1=0 and id_two_src=0 → both outputs 0.
- Load-use, FWD_EN=1: exe_mem_r_en=1, exe_dest=5, id_src2=5, id_two_src=1 → freeze=1.
  - Same stimulus with exe_mem_r_en=0 → freeze=0.
- Branch during hazard and during stall:
  - branch_taken=1 with h=1 → flush=1, freeze=0.
  - branch_taken=1 while BUSY → flush=0 until the DONE cycle, then flush=1.
- Reset mid-BUSY: assert rst at cycle 3 of a MEM_WAIT=8 access → all outputs 0 immediately, stall_cycles=0. After release with mem_r_en=1, a full 8-cycle stall restarts.
- Saturation (force-preload or long run): stall_cycles reaches 16'hFFFF and stays there.
